// File: rtl/wshb_ram_slave_if.sv
// -----------------------------------------------------------------------------
// wshb_ram_slave_if
// Wishbone B4 32-bit bus bundle (sys_clk domain) between a master and the
// on-chip RAM responder.
//   cyc, stb   : bus cycle valid / transfer strobe          (master -> slave)
//   we         : 1 = write, 0 = read                        (master -> slave)
//   adr        : byte address, bits [1:0] ignored           (master -> slave)
//   dat_ms     : write data                                 (master -> slave)
//   sel        : byte-lane enables                          (master -> slave)
//   cti, bte   : cycle type / burst type                    (master -> slave)
//   dat_sm     : read data, valid while ack=1               (slave -> master)
//   ack,err,rty: terminations                               (slave -> master)
// -----------------------------------------------------------------------------
interface wshb_ram_slave_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [31:0] dat_ms;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic [31:0] dat_sm;
   logic        ack;
   logic        err;
   logic        rty;

   modport master (
      output cyc, stb, we, adr, dat_ms, sel, cti, bte,
      input  dat_sm, ack, err, rty
   );

   modport slave (
      input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
      output dat_sm, ack, err, rty
   );
endinterface

// File: rtl/wshb_ram_slave.sv
// -----------------------------------------------------------------------------
// wshb_ram_slave
// Wishbone B4 responder backed by a synchronous single-port style RAM of
// 2**DEPTH_LOG2 32-bit words. Supports classic transfers with WAIT_STATES
// programmable wait cycles before the first termination, and linear
// incrementing bursts (cti=010, bte=00) with per-byte write enables.
//   sys_clk   : system clock, rising edge
//   sys_rst_n : asynchronous active-low reset
//   wshb      : Wishbone slave modport (see wshb_ram_slave_if)
// -----------------------------------------------------------------------------
module wshb_ram_slave #(
   parameter int unsigned DEPTH_LOG2  = 10,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   wshb_ram_slave_if.slave        wshb
);

   localparam int unsigned DEPTH = 2**DEPTH_LOG2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_CLASSIC_ACK,
      ST_BURST
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [DEPTH_LOG2-1:0] r_addr,  w_addr_nxt;
   logic [2:0]            r_wait,  w_wait_nxt;
   logic                  r_err,   w_err_nxt;    // pending first termination is err
   logic                  r_burst, w_burst_nxt;  // accepted transfer is a burst

   logic [31:0]           r_mem [DEPTH];
   logic [31:0]           r_rdata;

   logic [DEPTH_LOG2-1:0] w_wa;
   logic [DEPTH_LOG2-1:0] w_raddr;
   logic                  w_req;
   logic                  w_oor;
   logic                  w_start_err;
   logic                  w_is_burst;
   logic                  w_beat;
   logic                  w_ack;
   logic                  w_err;
   logic                  w_unused_ok;

   assign w_req       = wshb.cyc & wshb.stb;
   assign w_wa        = wshb.adr[DEPTH_LOG2+1:2];
   assign w_oor       = |wshb.adr[31:DEPTH_LOG2+2];
   assign w_is_burst  = (wshb.cti == 3'b010);
   assign w_start_err = w_oor | (w_is_burst & (wshb.bte != 2'b00));
   assign w_unused_ok = &{1'b0, wshb.adr[1:0]};

   // Burst beats are acked combinationally from stb so a master stall
   // drops ack in the same cycle; everything else is decoded from state,
   // which makes an asynchronous reset drop ack/err immediately.
   assign w_beat = (r_state == ST_BURST) & w_req;
   assign w_ack  = ((r_state == ST_CLASSIC_ACK) & ~r_err) | w_beat;
   assign w_err  = (r_state == ST_CLASSIC_ACK) & r_err;

   assign wshb.ack    = w_ack;
   assign wshb.err    = w_err;
   assign wshb.rty    = 1'b0;
   assign wshb.dat_sm = w_ack ? r_rdata : '0;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_wait  <= '0;
         r_err   <= 1'b0;
         r_burst <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
         r_wait  <= w_wait_nxt;
         r_err   <= w_err_nxt;
         r_burst <= w_burst_nxt;
      end
   end

   // The RAM read address always points at the word that will be presented
   // in the next ack cycle: the bus address while idle, the counter while
   // waiting, and counter+1 once a burst beat is being acked (prefetch).
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_wait_nxt  = r_wait;
      w_err_nxt   = r_err;
      w_burst_nxt = r_burst;
      w_raddr     = r_addr;
      unique case (r_state)
         ST_IDLE: begin
            w_raddr = w_wa;
            // ack/err are always low in IDLE, so a termination cycle can
            // never coincide with accepting a new request.
            if (w_req) begin
               w_addr_nxt  = w_wa;
               w_wait_nxt  = 3'(WAIT_STATES);
               w_err_nxt   = w_start_err;
               w_burst_nxt = w_is_burst;
               if (WAIT_STATES == 0)
                  w_state_nxt = (w_start_err || !w_is_burst) ? ST_CLASSIC_ACK : ST_BURST;
               else
                  w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            w_wait_nxt = r_wait - 3'd1;
            if (!wshb.cyc)
               w_state_nxt = ST_IDLE;
            else if (r_wait == 3'd1)
               w_state_nxt = (r_err || !r_burst) ? ST_CLASSIC_ACK : ST_BURST;
         end
         ST_CLASSIC_ACK: begin
            w_state_nxt = ST_IDLE;
         end
         ST_BURST: begin
            if (!wshb.cyc) begin
               w_state_nxt = ST_IDLE;
            end else if (wshb.stb) begin
               w_addr_nxt = r_addr + DEPTH_LOG2'(1);
               w_raddr    = r_addr + DEPTH_LOG2'(1);
               if (wshb.cti != 3'b010)
                  w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // RAM: writes only in ack cycles, so err cycles and cycles under reset
   // (state forced to IDLE) never modify contents.
   always_ff @(posedge sys_clk) begin
      r_rdata <= r_mem[w_raddr];
      if (w_ack && wshb.we) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (wshb.sel[i])
               r_mem[r_addr][8*i +: 8] <= wshb.dat_ms[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_wshb_ram_slave.sv
// -----------------------------------------------------------------------------
// tb_wshb_ram_slave
// Directed bench for wshb_ram_slave (DEPTH_LOG2=10, WAIT_STATES=1).
// Expected read data is pushed to a scoreboard queue when a read is issued
// and popped when the DUT acks it.
// -----------------------------------------------------------------------------
module tb_wshb_ram_slave;

   localparam int unsigned DL2 = 10;
   localparam int unsigned WS  = 1;

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   int unsigned checks    = 0;
   int unsigned errors    = 0;
   logic [31:0] sb [$];

   wshb_ram_slave_if bus();

   wshb_ram_slave #(
      .DEPTH_LOG2  (DL2),
      .WAIT_STATES (WS)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .wshb      (bus)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bus_idle();
      bus.cyc    = 1'b0;
      bus.stb    = 1'b0;
      bus.we     = 1'b0;
      bus.adr    = '0;
      bus.dat_ms = '0;
      bus.sel    = '0;
      bus.cti    = '0;
      bus.bte    = '0;
   endtask

   // Drive point: just after the rising edge. Sample point: falling edge.
   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic mid();
      @(negedge sys_clk);
   endtask

   task automatic pop_exp(output logic [31:0] e);
      if (sb.size() > 0) e = sb.pop_front();
      else               e = 32'hxxxxxxxx;
   endtask

   // Waits (bounded) for ack or err; returns number of idle samples before it.
   task automatic wait_term(output logic seen, output int unsigned lat);
      seen = 1'b0;
      lat  = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         mid();
         if (bus.ack || bus.err) seen = 1'b1;
         else                    lat++;
      end
   endtask

   // Classic transfer. For reads, dat is the expected read data.
   task automatic classic(input string tag, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel,
                          input logic [2:0] cti, input logic [1:0] bte, input logic exp_err);
      logic        seen;
      int unsigned lat;
      logic [31:0] e;
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.adr = adr;
      bus.dat_ms = we ? dat : '0; bus.sel = sel; bus.cti = cti; bus.bte = bte;
      if (!we && !exp_err) sb.push_back(dat);
      wait_term(seen, lat);
      if (!seen) begin
         chk({tag, " timeout"}, 32'd0, 32'd1);
      end else begin
         chk({tag, " latency"}, lat, WS + 1);
         chk({tag, " err"}, 32'(bus.err), 32'(exp_err));
         chk({tag, " ack"}, 32'(bus.ack), 32'(!exp_err));
         if (!we && !exp_err) begin
            pop_exp(e);
            chk({tag, " data"}, bus.dat_sm, e);
         end
      end
      step();
      bus_idle();
      mid();
      chk({tag, " single"}, 32'({bus.ack, bus.err}), 32'd0);
      step();
   endtask

   // Linear burst read of n beats; optional 2-cycle stall after beat
   // stall_after, optional abort (cyc drop) after beat abort_after.
   task automatic burst_read(input string tag, input logic [31:0] adr, input int unsigned n,
                             input int unsigned stall_after, input int unsigned abort_after);
      logic        seen;
      int unsigned lat;
      logic [31:0] e;
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = adr;
      bus.sel = '1; bus.bte = 2'b00; bus.cti = (n == 1) ? 3'b111 : 3'b010;
      wait_term(seen, lat);
      if (!seen) begin
         chk({tag, " timeout"}, 32'd0, 32'd1);
         bus_idle();
         sb.delete();
         step();
         return;
      end
      chk({tag, " latency"}, lat, WS + 1);
      for (int unsigned k = 0; k < n; k++) begin
         if (k > 0) mid();
         chk({tag, " ack"}, 32'(bus.ack), 32'd1);
         pop_exp(e);
         chk({tag, " data"}, bus.dat_sm, e);
         step();
         if (k + 1 == n || k + 1 == abort_after) begin
            bus_idle();
            sb.delete();
            break;
         end
         bus.adr = adr + 32'(4 * (k + 1));
         bus.cti = (k + 2 == n) ? 3'b111 : 3'b010;
         if (k + 1 == stall_after) begin
            bus.stb = 1'b0;
            repeat (2) begin
               mid();
               chk({tag, " stall"}, 32'(bus.ack), 32'd0);
               step();
            end
            bus.stb = 1'b1;
         end
      end
      mid();
      chk({tag, " end"}, 32'(bus.ack), 32'd0);
      step();
   endtask

   initial begin
      logic        seen;
      int unsigned lat;

      // Reset with an active request on the bus.
      bus_idle();
      bus.cyc = 1'b1;
      bus.stb = 1'b1;
      repeat (3) begin
         mid();
         chk("rst ack", 32'(bus.ack), 32'd0);
         chk("rst err", 32'(bus.err), 32'd0);
         chk("rst rty", 32'(bus.rty), 32'd0);
         chk("rst dat", bus.dat_sm, 32'd0);
      end
      bus_idle();
      step();
      sys_rst_n = 1'b1;
      step();

      // Classic write / read-back and byte enables.
      classic("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 3'b000, 2'b00, 1'b0);
      classic("rd10", 1'b0, 32'h10, 32'hDEADBEEF, 4'b1111, 3'b000, 2'b00, 1'b0);
      classic("wrbe", 1'b1, 32'h10, 32'h0000AB00, 4'b0010, 3'b000, 2'b00, 1'b0);
      classic("rdbe", 1'b0, 32'h10, 32'hDEADABEF, 4'b1111, 3'b000, 2'b00, 1'b0);

      // Preload 0x100..0x10C with 1..4.
      for (int unsigned i = 0; i < 4; i++)
         classic("pre", 1'b1, 32'h100 + 32'(4 * i), 32'(i + 1), 4'b1111, 3'b000, 2'b00, 1'b0);

      for (int unsigned i = 1; i <= 4; i++) sb.push_back(32'(i));
      burst_read("burst", 32'h100, 4, 0, 0);

      for (int unsigned i = 1; i <= 4; i++) sb.push_back(32'(i));
      burst_read("stall", 32'h100, 4, 2, 0);

      for (int unsigned i = 1; i <= 4; i++) sb.push_back(32'(i));
      burst_read("abort", 32'h100, 4, 0, 2);
      classic("rd_abort", 1'b0, 32'h100, 32'd1, 4'b1111, 3'b000, 2'b00, 1'b0);

      // Errors: out of range write must not alias onto word 0.
      classic("wr0", 1'b1, 32'h0, 32'h00C0FFEE, 4'b1111, 3'b000, 2'b00, 1'b0);
      classic("oor", 1'b1, 32'(4) << DL2, 32'h12345678, 4'b1111, 3'b000, 2'b00, 1'b1);
      classic("rd0", 1'b0, 32'h0, 32'h00C0FFEE, 4'b1111, 3'b000, 2'b00, 1'b0);
      classic("bte", 1'b0, 32'h100, 32'd0, 4'b1111, 3'b010, 2'b01, 1'b1);

      // Burst starting at the last word wraps to word 0.
      classic("wrtop", 1'b1, (32'(4) << DL2) - 32'd4, 32'hA5A5A5A5, 4'b1111, 3'b000, 2'b00, 1'b0);
      sb.push_back(32'hA5A5A5A5);
      sb.push_back(32'h00C0FFEE);
      burst_read("wrap", (32'(4) << DL2) - 32'd4, 2, 0, 0);

      // Reset mid-burst drops ack without a clock edge.
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h100;
      bus.sel = '1; bus.cti = 3'b010; bus.bte = 2'b00;
      wait_term(seen, lat);
      chk("rstb seen", 32'(bus.ack), 32'd1);
      #1 sys_rst_n = 1'b0;
      #1;
      chk("rstb ack", 32'(bus.ack), 32'd0);
      chk("rstb dat", bus.dat_sm, 32'd0);
      bus_idle();
      step();
      sys_rst_n = 1'b1;
      step();

      // Reset during a write ack cycle: the write is not committed.
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 32'h104;
      bus.dat_ms = 32'hBAD0BAD0; bus.sel = '1; bus.cti = 3'b000; bus.bte = 2'b00;
      wait_term(seen, lat);
      chk("rstw seen", 32'(bus.ack), 32'd1);
      #1 sys_rst_n = 1'b0;
      #1;
      chk("rstw ack", 32'(bus.ack), 32'd0);
      bus_idle();
      step();
      sys_rst_n = 1'b1;
      step();
      classic("rd104", 1'b0, 32'h104, 32'd2, 4'b1111, 3'b000, 2'b00, 1'b0);
      classic("rd100", 1'b0, 32'h100, 32'd1, 4'b1111, 3'b000, 2'b00, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wshb_ram_slave.md
# wshb_ram_slave

- Wishbone B4 responder backed by an on-chip synchronous RAM.
- It is the slave end of the 32-bit `sys_clk` Wishbone bus, the same bus shape as the SDRAM and stream ports in the top level. It stands in for the SDRAM controller in simulation and provides a small scratch/frame-line memory on the FPGA.
- It supports classic single transfers with programmable wait states and linear incrementing bursts (CTI=010, BTE=00), with per-byte write enables.

## Interface
Parameters:
- DEPTH_LOG2, 10: memory holds 2**DEPTH_LOG2 32-bit words; byte address window is 0 .. 4*2**DEPTH_LOG2-1.
- WAIT_STATES, 1: extra cycles (0..7) inserted before the first ack of every transfer/burst.

Ports:
- sys_clk  in  1  system clock (100 MHz); everything is synchronous to its rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- wshb_cyc  in  1  bus cycle valid.
- wshb_stb  in  1  strobe; a transfer is requested only when cyc&stb.
- wshb_we  in  1  1 = write, 0 = read.
- wshb_adr  in  32  byte address; bits [1:0] ignored.
- wshb_dat_ms  in  32  write data.
- wshb_sel  in  4  byte enables; sel[i] enables byte lane i (bits 8i+7:8i).
- wshb_cti  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst; other codes are treated as 000.
- wshb_bte  in  2  burst type; only 00 (linear) is legal.
- wshb_dat_sm  out  32  read data; valid only while ack=1.
- wshb_ack  out  1  normal termination.
- wshb_err  out  1  error termination.
- wshb_rty  out  1  tied to 0.

## Operation
- **Reset (sys_rst_n=0, asynchronous):**
  - ack=0, err=0, dat_sm=0, FSM=IDLE, burst address counter=0.
  - RAM contents are not reset.
  - Reset asserted mid-transfer drops ack/err immediately. No partial write is committed after reset assertion.
- **Word address:** wa = adr[DEPTH_LOG2+1:2].
- **Out of range:** any set bit in adr[31:DEPTH_LOG2+2]. This is checked at transfer/burst start only.
- **FSM states:** IDLE, WAIT, CLASSIC_ACK, BURST.
  - IDLE: a request (cyc&stb) is accepted only when ack=0 and err=0 in the same cycle, so the cycle carrying a termination never starts a new transfer. On acceptance:
    - Load the counter with wa and capture the transfer type (burst if cti=010).
    - Load the wait counter with WAIT_STATES.
    - Go to WAIT, or terminate immediately if WAIT_STATES=0.
  - WAIT: decrement the wait counter. At zero, issue the first termination:
    - err if out of range, or if cti=010 with bte≠00.
    - Otherwise ack.
    - Then go to CLASSIC_ACK (classic or error) or BURST.
  - CLASSIC_ACK: ack/err high exactly one cycle, then IDLE.
  - BURST:
    - ack=1 in every cycle where cyc&stb=1. Each acked beat increments the counter.
    - The counter wraps modulo 2**DEPTH_LOG2; there is no error at the top of memory.
    - The beat acked with cti=111 ends the burst and returns to IDLE.
    - stb=0 with cyc=1 is a master stall: ack=0 and the counter holds.
    - cyc=0 aborts to IDLE.
- **Writes:**
  - Committed in the ack cycle to the current word address (wa for classic, counter for burst).
  - Only lanes with sel=1 are updated.
  - An err cycle never writes.
- **Reads:** dat_sm = RAM[current word address], presented in the ack cycle. The RAM has 1-cycle synchronous read, so the RAM read address for beat k+1 is issued during beat k (prefetch from counter+1).
- **Ignored inputs:** stb with cyc=0 is ignored. we/sel/dat_ms are sampled per beat in bursts; mixing reads and writes in one burst is illegal and unchecked.

## Timing
- Request sampled at edge N (IDLE): first ack/err is registered at edge N+WAIT_STATES and high for the cycle after that edge.
- Classic transfer: one termination per request. Minimum request-to-request spacing is WAIT_STATES+2 cycles.
- Burst of L beats with no stalls: ack high for L consecutive cycles after the wait states. ack=0 in the cycle after the cti=111 beat.
- err has the same timing as the first ack would have had. ack and err are never high together.
- Back-to-back bursts: a new burst is accepted no earlier than the cycle after the final ack goes low.

## Test plan
1. **Reset:** hold sys_rst_n=0, drive cyc=stb=1 -> ack=err=rty=0 and dat_sm=0 throughout. Assert sys_rst_n=0 mid-burst -> ack drops in the same cycle, without waiting for a clock edge.
2. **Classic write/read-back:** WAIT_STATES=1, write 0xDEADBEEF to adr 0x10 with sel=1111.
   - ack appears exactly once, 1 cycle after the sampling edge.
   - Reading 0x10 returns 0xDEADBEEF with ack.
3. **Byte enable:** write 0x0000AB00 to adr 0x10 with sel=0010 -> a read returns 0xDEADABEF.
4. **Burst read:**
   - Preload words 0x100..0x10C with 1,2,3,4.
   - Issue a 4-beat burst (cti 010,010,010,111) -> 4 consecutive ack cycles with dat_sm=1,2,3,4, and ack=0 on the following cycle.
5. **Master stall and abort:**
   - Stall: drop stb for 2 cycles between beats 2 and 3 -> ack=0 in those cycles; beat 3 returns 3 and beat 4 returns 4.
   - Abort: drop cyc after beat 2 -> FSM is IDLE and a subsequent classic read of 0x100 returns 1.
6. **Errors:**
   - adr=4<<DEPTH_LOG2 -> err high one cycle, ack=0, no RAM change.
   - cti=010 with bte=01 -> err.
   - A burst starting at the last word wraps: its second beat reads word 0.
